my_mem_par: RTL
===============

Name: my_mem_par

Overview:
Parametrised single-port synchronous memory with per-lane parity generation on write and parity checking on read. It is the successor to the fixed 8-bit parity memory and generalises data width, depth and lane count. It adds a post-reset initialisation sweep, one-cycle registered reads, illegal-operation detection, an error-injection hook and a saturating error counter. It sits behind the memory interface and is exercised directly by the memory testbenches.

Parameters:
DATA_W, 8, data width in bits; must be a multiple of LANE_W
LANE_W, 8, bits per parity lane; LANES = DATA_W/LANE_W (derived)
ADDR_W, 16, address port width
DEPTH, 64, number of words; must be ≤ 2**ADDR_W
ERR_CNT_W, 16, error counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
write  in  1  write request
read  in  1  read request
address  in  ADDR_W  word address
data_in  in  DATA_W  write data
inject_err  in  1  when set with a write, store lane-0 parity inverted
clr_err  in  1  synchronous clear of error_count
ready  out  1  high once initialisation is complete
data_out  out  DATA_W+LANES  {parity[LANES-1:0], data} of the last read
data_valid  out  1  one-cycle pulse, data_out updated this cycle
parity_err  out  1  one-cycle pulse with data_valid on parity mismatch
illegal_op  out  1  one-cycle pulse for rejected request
error_count  out  ERR_CNT_W  saturating count of error events

Behaviour:
- Reset (async assert, sync release): ready, data_out, data_valid, parity_err, illegal_op, error_count are all 0. FSM goes to INIT with the sweep pointer at 0.
- FSM INIT: each cycle writes word 0 with parity 0 at the pointer and increments the pointer. After address DEPTH-1, go to RUN. ready rises on the first RUN cycle, so INIT lasts exactly DEPTH cycles.
- While ready=0, write/read/inject_err are ignored. They are not flagged and not counted.
- Parity: lane i parity = XOR of data[i*LANE_W +: LANE_W]. This is even parity, giving the {^data,data} layout for DATA_W=8.
- RUN write (write=1, read=0, address<DEPTH): the word is stored at the clock edge. With inject_err=1, stored parity[0] is inverted. No output changes.
- RUN read (read=1, write=0, address<DEPTH): latency is 1 cycle. On the next edge, data_out is loaded with the stored word and data_valid pulses. The stored parity is not corrected or recomputed into data_out.
  - On that same edge, parity_err = 1 if any lane's recomputed parity differs from its stored bit.
- data_out holds its value until the next successful read.
- Illegal: read=1 and write=1 together, or (read|write) with address≥DEPTH. Neither operation is performed, memory is unchanged, and illegal_op pulses on the next edge. data_valid stays 0.
- Back-to-back reads every cycle give data_valid high continuously. A write followed by a read of the same address in the next cycle returns the new data.
- error_count: +1 on each edge where parity_err or illegal_op is being asserted; both together count once. It saturates at 2**ERR_CNT_W-1.
  - clr_err has priority: the count becomes 0 even if an event occurs in the same cycle.
- Reset mid-operation: a pending read result is discarded. INIT reruns, and all contents read back as 0 after ready.

Test Plan:
- Reset then idle (DEPTH=64) -> ready=0 for 64 cycles, ready=1 on cycle 65; a read of addr 0x0010 gives data_out=0x000, data_valid=1, parity_err=0.
- Write 0x07 to 0x0003, read 0x0003 next cycle -> data_out=0x107, parity_err=0; write 0xA5 to 0x0021, read -> 0x0A5.
- Write 0x3C to 0x0005 with inject_err=1, then read -> data_out=0x13C, parity_err=1, error_count=1.
- read=write=1 at 0x0002, then write 0x40 to 0x0050 -> illegal_op pulses twice, no data_valid, memory unchanged, error_count=2; clr_err=1 together with a third illegal op -> error_count=0.
- DATA_W=16, LANE_W=8: write 0x0180 then read -> data_out=0x30180 (both lanes odd weight). Six random writes, then shuffled reads -> all match, error_count=0.
- ERR_CNT_W=2, five illegal ops -> error_count sticks at 3. Assert rst_n=0 one cycle after a read request -> no data_valid, outputs 0, INIT restarts.

Source files
------------

// File: rtl/my_mem_par.sv
// Single-port parity-protected memory: per-lane even parity on write, checked on read.
// Reads return one cycle later; no backpressure, requests are ignored until the init sweep finishes.
module my_mem_par #(
  parameter int DATA_W    = 8,
  parameter int LANE_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 64,
  parameter int ERR_CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           write,
  input  logic                           read,
  input  logic [ADDR_W-1:0]              address,
  input  logic [DATA_W-1:0]              data_in,
  input  logic                           inject_err,
  input  logic                           clr_err,
  output logic                           ready,
  output logic [DATA_W+DATA_W/LANE_W-1:0] data_out,
  output logic                           data_valid,
  output logic                           parity_err,
  output logic                           illegal_op,
  output logic [ERR_CNT_W-1:0]           error_count
);

  localparam int LANES  = DATA_W / LANE_W;
  localparam int WORD_W = DATA_W + LANES;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              in_range, do_write, do_read, req_illegal;
  logic              perr_nxt;
  logic [IDX_W-1:0]  addr_idx;
  logic [WORD_W-1:0] rd_word;
  logic [LANES-1:0]  wr_par;

  function automatic logic [LANES-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [LANES-1:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) p[i] = ^d[i*LANE_W +: LANE_W];
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      INIT: begin
        ptr_nxt = ptr + IDX_W'(1);
        if (ptr == IDX_W'(DEPTH - 1)) begin
          state_nxt = RUN;
          ptr_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign ready       = (state == RUN);
  assign addr_idx    = address[IDX_W-1:0];
  assign in_range    = ({1'b0, address} < (ADDR_W+1)'(DEPTH));
  assign do_write    = ready && write && !read && in_range;
  assign do_read     = ready && read && !write && in_range;
  assign req_illegal = ready && (read || write) && ((read && write) || !in_range);
  assign wr_par      = lane_par(data_in) ^ LANES'(inject_err);
  assign rd_word     = mem[addr_idx];
  assign perr_nxt    = do_read && (lane_par(rd_word[DATA_W-1:0]) != rd_word[WORD_W-1:DATA_W]);

  // Storage has no reset: the init sweep is what clears it after every reset.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[ptr] <= '0;
    else if (do_write)
      mem[addr_idx] <= {wr_par, data_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      illegal_op  <= 1'b0;
      error_count <= '0;
    end else begin
      data_valid <= do_read;
      parity_err <= perr_nxt;
      illegal_op <= req_illegal;
      if (do_read)
        data_out <= rd_word;
      // Clear wins over a coincident event; a parity error and illegal op cannot coincide.
      if (clr_err)
        error_count <= '0;
      else if ((perr_nxt || req_illegal) && (error_count != '1))
        error_count <= error_count + ERR_CNT_W'(1);
    end
  end

endmodule
